// File: rtl/riscv_queue_ahb_drain.sv
// ---------------------------------------------------------------------------
// riscv_queue_ahb_drain
//
// Drains a fall-through write queue onto an AHB-Lite master port as SINGLE
// write transfers. Address phase n+1 overlaps data phase n. A bus ERROR
// cancels the following address phase, raises a sticky err_o and records the
// failing address. Draining stays stopped until err_clr_i or clr_i.
//
// Ports
//   rst_ni, clk_i        asynchronous active-low reset, rising-edge clock
//   clr_i                synchronous abort: idles the bus, clears err_o/cancel
//   q_empty_i, q_i       queue head {size, addr, data}, valid when not empty
//   q_re_o               pop strobe, one per accepted address phase
//   HADDR..HMASTLOCK     AHB-Lite master outputs (write-only, SINGLE bursts)
//   HREADY, HRESP        AHB-Lite slave response
//   busy_o               queue not empty or data phase outstanding
//   err_o, err_addr_o    sticky bus error and address of the failed write
//   err_clr_i            clears err_o
// ---------------------------------------------------------------------------
module riscv_queue_ahb_drain #(
  parameter  int PLEN  = 32,
  parameter  int XLEN  = 64,
  localparam int QBITS = 3 + PLEN + XLEN
) (
  input  logic             rst_ni,
  input  logic             clk_i,
  input  logic             clr_i,

  input  logic             q_empty_i,
  input  logic [QBITS-1:0] q_i,
  output logic             q_re_o,

  output logic [PLEN-1:0]  HADDR,
  output logic [XLEN-1:0]  HWDATA,
  output logic             HWRITE,
  output logic [2:0]       HSIZE,
  output logic [2:0]       HBURST,
  output logic [3:0]       HPROT,
  output logic [1:0]       HTRANS,
  output logic             HMASTLOCK,
  input  logic             HREADY,
  input  logic             HRESP,

  output logic             busy_o,
  output logic             err_o,
  output logic [PLEN-1:0]  err_addr_o,
  input  logic             err_clr_i
);

  typedef enum logic [1:0] {
    TRANS_IDLE   = 2'b00,
    TRANS_NONSEQ = 2'b10
  } htrans_e;

  logic [2:0]      q_size;
  logic [PLEN-1:0] q_addr;
  logic [XLEN-1:0] q_data;

  assign {q_size, q_addr, q_data} = q_i;

  // Data-phase state of the most recently accepted address phase.
  logic            dph_valid;
  logic [PLEN-1:0] dph_addr;
  logic [XLEN-1:0] dph_wdata;

  // Set during the two-cycle ERROR response to suppress the next address phase.
  logic            cancel;

  logic addr_req;   // NONSEQ presented this cycle
  logic addr_acc;   // address phase accepted this cycle
  logic err_first;  // first cycle of an ERROR response
  logic err_done;   // second (completing) cycle of an ERROR response

  // NOTE: every signal driven from always_comb gets a value on every path;
  // a missing assignment would infer a latch.
  always_comb begin
    // rst_ni gates the request combinationally so reset idles the bus at once.
    addr_req  = rst_ni & ~q_empty_i & ~err_o & ~clr_i & ~cancel;
    addr_acc  = addr_req & HREADY;
    err_first = dph_valid & HRESP & ~HREADY;
    err_done  = dph_valid & HRESP &  HREADY;
  end

  assign HTRANS    = addr_req ? TRANS_NONSEQ : TRANS_IDLE;
  assign HADDR     = q_addr;
  assign HSIZE     = q_size;
  assign HWDATA    = dph_wdata;
  assign HWRITE    = 1'b1;
  assign HBURST    = 3'b000;
  assign HPROT     = 4'b0011;
  assign HMASTLOCK = 1'b0;
  assign q_re_o    = addr_acc;
  assign busy_o    = ~q_empty_i | dph_valid;

  // The data phase only advances when HREADY=1, so HWDATA holds through wait
  // states and through clr_i (an AHB data phase cannot be aborted).
  // NOTE: the write-data/address registers are reset too, because HWDATA
  // must read zero out of reset rather than whatever the flops power up to.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      dph_valid <= 1'b0;
      dph_addr  <= '0;
      dph_wdata <= '0;
    end else if (HREADY) begin
      dph_valid <= addr_acc;
      if (addr_acc) begin
        dph_addr  <= q_addr;
        dph_wdata <= q_data;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cancel <= 1'b0;
    end else if (clr_i) begin
      cancel <= 1'b0;
    end else if (err_first) begin
      cancel <= 1'b1;
    end else if (HREADY) begin
      cancel <= 1'b0;
    end
  end

  // A completing error outranks err_clr_i so a fresh failure is never lost.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_o      <= 1'b0;
      err_addr_o <= '0;
    end else begin
      if (clr_i) begin
        err_o <= 1'b0;
      end else if (err_done) begin
        err_o <= 1'b1;
      end else if (err_clr_i) begin
        err_o <= 1'b0;
      end
      if (err_first) begin
        err_addr_o <= dph_addr;
      end
    end
  end

endmodule

// File: tb/tb_riscv_queue_ahb_drain.sv
// ---------------------------------------------------------------------------
// tb_riscv_queue_ahb_drain
//
// Directed scenarios (reset, single write, back-to-back, wait states, bus
// error, clear, reset mid-transfer) followed by a randomized drain run.
// A transaction-level reference tracks the upstream queue and the one
// outstanding data phase; completed writes are compared in order against
// everything pushed.
// ---------------------------------------------------------------------------
module tb_riscv_queue_ahb_drain;

  localparam int PLEN  = 32;
  localparam int XLEN  = 64;
  localparam int QBITS = 3 + PLEN + XLEN;

  typedef struct packed {
    logic [2:0]      size;
    logic [PLEN-1:0] addr;
    logic [XLEN-1:0] data;
  } entry_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             clr;
  logic             q_empty;
  logic [QBITS-1:0] q;
  logic             q_re;
  logic [PLEN-1:0]  haddr;
  logic [XLEN-1:0]  hwdata;
  logic             hwrite;
  logic [2:0]       hsize;
  logic [2:0]       hburst;
  logic [3:0]       hprot;
  logic [1:0]       htrans;
  logic             hmastlock;
  logic             hready;
  logic             hresp;
  logic             busy;
  logic             err;
  logic [PLEN-1:0]  err_addr;
  logic             err_clr;

  entry_t mq[$];     // upstream queue contents, head = mq[0]
  entry_t sent[$];   // entries pushed during the random run
  entry_t done[$];   // writes whose data phase completed
  entry_t m_dph_e;   // entry in the outstanding data phase
  bit     m_dph;     // a data phase is outstanding

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  riscv_queue_ahb_drain #(.PLEN(PLEN), .XLEN(XLEN)) dut (
    .rst_ni     (rst_n),
    .clk_i      (clk),
    .clr_i      (clr),
    .q_empty_i  (q_empty),
    .q_i        (q),
    .q_re_o     (q_re),
    .HADDR      (haddr),
    .HWDATA     (hwdata),
    .HWRITE     (hwrite),
    .HSIZE      (hsize),
    .HBURST     (hburst),
    .HPROT      (hprot),
    .HTRANS     (htrans),
    .HMASTLOCK  (hmastlock),
    .HREADY     (hready),
    .HRESP      (hresp),
    .busy_o     (busy),
    .err_o      (err),
    .err_addr_o (err_addr),
    .err_clr_i  (err_clr)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic entry_t mk(input logic [2:0] size, input logic [PLEN-1:0] addr,
                                input logic [XLEN-1:0] data);
    entry_t e;
    e.size = size;
    e.addr = addr;
    e.data = data;
    return e;
  endfunction

  function automatic entry_t rnd_entry();
    logic [PLEN-1:0] a;
    a = $urandom;
    return mk(3'($urandom_range(0, 3)), a & ~32'h7, {$urandom, $urandom});
  endfunction

  task automatic refresh();
    q_empty = (mq.size() == 0);
    q       = (mq.size() != 0) ? mq[0] : '0;
  endtask

  // Outputs are sampled on the falling edge; inputs change 1 time unit after
  // the rising edge. The upstream queue pops when it saw q_re_o at the edge.
  task automatic settle();
    @(negedge clk);
  endtask

  task automatic advance();
    logic pop;
    pop = q_re;
    @(posedge clk);
    #1;
    if (pop === 1'b1 && mq.size() != 0) void'(mq.pop_front());
    refresh();
  endtask

  // One error-free bus cycle checked against the transaction-level reference.
  task automatic model_cycle(input logic rdy);
    logic nonseq;
    hready = rdy;
    hresp  = 1'b0;
    settle();
    nonseq = (mq.size() != 0);
    check("htrans", htrans, nonseq ? 2'b10 : 2'b00);
    if (nonseq) begin
      check("haddr", haddr, mq[0].addr);
      check("hsize", hsize, mq[0].size);
    end
    check("q_re", q_re, nonseq & rdy);
    check("busy", busy, nonseq | m_dph);
    if (m_dph) check("hwdata", hwdata, m_dph_e.data);
    if (rdy) begin
      if (m_dph) done.push_back(m_dph_e);
      m_dph = nonseq;
      if (nonseq) m_dph_e = mq[0];
    end
    advance();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    entry_t e;
    logic [XLEN-1:0] c0;
    int n;

    hready = 1'b1; hresp = 1'b0; clr = 1'b0; err_clr = 1'b0; m_dph = 1'b0;
    rst_n = 1'b0;
    mq.push_back(mk(3'd2, 32'h1000, 64'hDEADBEEF));
    refresh();

    // Reset with a non-empty queue
    repeat (2) @(posedge clk);
    settle();
    check("rst_htrans",   htrans,   2'b00);
    check("rst_q_re",     q_re,     1'b0);
    check("rst_hwdata",   hwdata,   64'h0);
    check("rst_err",      err,      1'b0);
    check("rst_err_addr", err_addr, 32'h0);
    check("rst_busy",     busy,     1'b1);
    check("const_bus",    {hwrite, hburst, hprot, hmastlock}, {1'b1, 3'b000, 4'b0011, 1'b0});
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Single write
    settle();
    check("sw_htrans", htrans, 2'b10);
    check("sw_haddr",  haddr,  32'h1000);
    check("sw_hsize",  hsize,  3'd2);
    check("sw_q_re",   q_re,   1'b1);
    advance();
    settle();
    check("sw_hwdata",  hwdata, 64'h00000000DEADBEEF);
    check("sw_htrans1", htrans, 2'b00);
    check("sw_busy1",   busy,   1'b1);
    advance();
    settle();
    check("sw_busy2", busy, 1'b0);
    advance();

    // Back-to-back
    for (int i = 0; i < 3; i++) mq.push_back(mk(3'd3, 32'(8 * i), {$urandom, $urandom}));
    refresh();
    repeat (4) model_cycle(1'b1);

    // Wait states during the data phase of 0x8 while 0x10 is at the head
    for (int i = 0; i < 3; i++) mq.push_back(mk(3'd3, 32'(8 * i), {$urandom, $urandom}));
    refresh();
    model_cycle(1'b1);
    model_cycle(1'b1);
    model_cycle(1'b0);
    model_cycle(1'b0);
    model_cycle(1'b1);
    model_cycle(1'b1);

    // Bus error on 0x8, then err_clr_i resumes at 0x10
    for (int i = 0; i < 4; i++) mq.push_back(mk(3'd3, 32'(8 * i), {$urandom, $urandom}));
    refresh();
    model_cycle(1'b1);
    model_cycle(1'b1);
    c0 = m_dph_e.data;
    hready = 1'b0; hresp = 1'b1;
    settle();
    check("err1_htrans", htrans, 2'b10);
    check("err1_haddr",  haddr,  32'h10);
    check("err1_q_re",   q_re,   1'b0);
    check("err1_hwdata", hwdata, c0);
    advance();
    hready = 1'b1; hresp = 1'b1;
    settle();
    check("err2_htrans",   htrans,   2'b00);
    check("err2_q_re",     q_re,     1'b0);
    check("err2_err",      err,      1'b0);
    check("err2_err_addr", err_addr, 32'h8);
    advance();
    hresp = 1'b0;
    settle();
    check("errd_htrans",   htrans,   2'b00);
    check("errd_err",      err,      1'b1);
    check("errd_err_addr", err_addr, 32'h8);
    check("errd_q_re",     q_re,     1'b0);
    check("errd_busy",     busy,     1'b1);
    advance();
    err_clr = 1'b1;
    settle();
    check("errclr_htrans", htrans, 2'b00);
    check("errclr_err",    err,    1'b1);
    advance();
    err_clr = 1'b0;
    m_dph   = 1'b0;
    check("errclr_done",   err,      1'b0);
    check("errclr_hold",   err_addr, 32'h8);
    check("errclr_qsize",  mq.size(), 2);
    repeat (3) model_cycle(1'b1);

    // HRESP with no outstanding data phase is ignored
    hready = 1'b0; hresp = 1'b1;
    settle();
    advance();
    hready = 1'b1;
    settle();
    advance();
    hresp = 1'b0;
    check("stray_err", err, 1'b0);
    mq.push_back(mk(3'd1, 32'h30, {$urandom, $urandom}));
    refresh();
    repeat (2) model_cycle(1'b1);

    // Error completion coinciding with err_clr_i keeps err_o; clr_i clears it
    mq.push_back(mk(3'd3, 32'h40, {$urandom, $urandom}));
    mq.push_back(mk(3'd3, 32'h48, {$urandom, $urandom}));
    refresh();
    model_cycle(1'b1);
    hready = 1'b0; hresp = 1'b1;
    settle();
    check("err3_q_re", q_re, 1'b0);
    advance();
    hready = 1'b1; err_clr = 1'b1;
    settle();
    check("err4_htrans", htrans, 2'b00);
    advance();
    err_clr = 1'b0; hresp = 1'b0;
    check("coinc_err",      err,      1'b1);
    check("coinc_err_addr", err_addr, 32'h40);
    clr = 1'b1;
    settle();
    check("clrerr_htrans", htrans, 2'b00);
    check("clrerr_q_re",   q_re,   1'b0);
    advance();
    clr   = 1'b0;
    m_dph = 1'b0;
    check("clrerr_err", err, 1'b0);
    repeat (2) model_cycle(1'b1);

    // clr_i during a stalled data phase
    mq.push_back(mk(3'd3, 32'h20, {$urandom, $urandom}));
    mq.push_back(mk(3'd3, 32'h28, {$urandom, $urandom}));
    refresh();
    model_cycle(1'b1);
    c0  = m_dph_e.data;
    clr = 1'b1; hready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      settle();
      check("clr_htrans", htrans, 2'b00);
      check("clr_q_re",   q_re,   1'b0);
      check("clr_hwdata", hwdata, c0);
      check("clr_busy",   busy,   1'b1);
      advance();
    end
    hready = 1'b1;
    settle();
    check("clr_done_hwdata", hwdata, c0);
    check("clr_done_q_re",   q_re,   1'b0);
    advance();
    settle();
    check("clr_after_htrans", htrans, 2'b00);
    check("clr_after_busy",   busy,   1'b1);
    check("clr_after_qsize",  mq.size(), 1);
    advance();
    clr   = 1'b0;
    m_dph = 1'b0;
    repeat (3) model_cycle(1'b1);

    // Reset asserted mid-transfer drops it without a pop
    mq.push_back(mk(3'd3, 32'h50, {$urandom, $urandom}));
    mq.push_back(mk(3'd3, 32'h58, {$urandom, $urandom}));
    refresh();
    model_cycle(1'b1);
    rst_n = 1'b0;
    settle();
    check("mrst_htrans", htrans, 2'b00);
    check("mrst_q_re",   q_re,   1'b0);
    check("mrst_hwdata", hwdata, 64'h0);
    check("mrst_busy",   busy,   1'b1);
    advance();
    check("mrst_qsize", mq.size(), 1);
    rst_n = 1'b1;
    m_dph = 1'b0;
    repeat (2) model_cycle(1'b1);

    // Randomized drain with random wait states and random upstream pushes
    sent.delete();
    done.delete();
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 2) == 0) begin
        e = rnd_entry();
        mq.push_back(e);
        sent.push_back(e);
        refresh();
      end
      model_cycle($urandom_range(0, 3) != 0);
    end
    n = 0;
    while ((mq.size() != 0 || m_dph) && n < 100) begin
      model_cycle(1'b1);
      n++;
    end
    check("drain_in_time", n < 100, 1'b1);
    check("write_count", done.size(), sent.size());
    for (int i = 0; i < sent.size(); i++) begin
      if (i < done.size()) check("write_order", done[i], sent[i]);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
